// File: rtl/modulator_regs_pkg.sv
// Shared definitions for the modulator PS register bank: register offsets,
// word-index decode, CTRL bit positions, default ID value and a byte-lane
// merge helper used by every RW register.
package modulator_regs_pkg;

    // Byte offsets of the registers as seen by the PS
    localparam logic [15:0] OFS_CTRL    = 16'h0000;
    localparam logic [15:0] OFS_DUTY    = 16'h0004;
    localparam logic [15:0] OFS_IRQ_THR = 16'h0008;
    localparam logic [15:0] OFS_STATUS  = 16'h000C;
    localparam logic [15:0] OFS_IRQ_CLR = 16'h0010;
    localparam logic [15:0] OFS_PER_CNT = 16'h0014;
    localparam logic [15:0] OFS_ID      = 16'h0018;
    localparam logic [15:0] OFS_RSVD    = 16'h001C;

    // Word index decoded from address bits [4:2]
    typedef enum logic [2:0] {
        REG_CTRL    = OFS_CTRL[4:2],
        REG_DUTY    = OFS_DUTY[4:2],
        REG_IRQ_THR = OFS_IRQ_THR[4:2],
        REG_STATUS  = OFS_STATUS[4:2],
        REG_IRQ_CLR = OFS_IRQ_CLR[4:2],
        REG_PER_CNT = OFS_PER_CNT[4:2],
        REG_ID      = OFS_ID[4:2],
        REG_RSVD    = OFS_RSVD[4:2]
    } reg_idx_e;

    // CTRL register bit positions
    localparam int CTRL_MOD_EN_BIT = 0;
    localparam int CTRL_SEL_BIT    = 1;
    localparam int CTRL_IRQ_EN_BIT = 2;

    // STATUS register bit positions
    localparam int STAT_IRQ_PEND_BIT = 0;
    localparam int STAT_PWM_BIT      = 1;

    localparam logic [31:0] ID_VALUE_DEFAULT = 32'h4D4F_4401;

    // Only address bits [4:2] select a register; the rest are don't-care
    function automatic reg_idx_e addr_to_idx(input logic [2:0] word_addr);
        return reg_idx_e'(word_addr);
    endfunction

    // Replace each byte lane of old_val whose enable is set with new_val
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  be);
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) begin
                res[8*b +: 8] = new_val[8*b +: 8];
            end else begin
                res[8*b +: 8] = old_val[8*b +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/modulator_bram_regs_if.sv
// BRAM-style PS access port (pl_bram_soc_*) bundled as an interface.
// The PS side drives address/data/strobes; the register bank returns dout.
interface modulator_bram_regs_if;
    logic [15:0] addr;
    logic [31:0] din;
    logic [31:0] dout;
    logic        en;
    logic [3:0]  we;
    logic        rst;

    modport master (
        output addr,
        output din,
        output en,
        output we,
        output rst,
        input  dout
    );

    modport slave (
        input  addr,
        input  din,
        input  en,
        input  we,
        input  rst,
        output dout
    );
endinterface

// File: rtl/modulator_period_irq.sv
// Period event logic for the modulator register bank: detects rising edges
// of the PWM output while the modulator is enabled, counts them against the
// programmable threshold, and owns the pending-interrupt flag.
// Optional feature: define MODULATOR_REGS_PER_CNT_EN to build the free-running
// 32-bit period counter; otherwise per_cnt_o is tied to zero.
module modulator_period_irq
    import modulator_regs_pkg::*;
#(
    parameter int THR_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             pwm_i,
    input  logic             mod_en_i,
    input  logic [THR_W-1:0] thr_i,
    input  logic             thr_clr_i,
    input  logic             irq_clr_i,
    output logic             irq_pend_o,
    output logic             irq_pend_d_o,
    output logic [31:0]      per_cnt_o
);

    logic             pwm_d_q;
    logic             pwm_d_d;
    logic [THR_W-1:0] thr_cnt_q;
    logic [THR_W-1:0] thr_cnt_d;
    logic             irq_pend_q;
    logic             irq_pend_d;
    logic [THR_W-1:0] thr_inc_s;
    logic             evt_s;
    logic             irq_set_s;

    // Edge detect, threshold counting and pending-flag next state
    always_comb begin
        pwm_d_d   = pwm_i;
        evt_s     = pwm_i & ~pwm_d_q & mod_en_i;
        thr_inc_s = thr_cnt_q + THR_W'(1);
        thr_cnt_d = thr_cnt_q;
        irq_set_s = 1'b0;
        // A threshold rewrite or modulator disable restarts the count and
        // swallows an edge landing in the same cycle.
        if (thr_clr_i) begin
            thr_cnt_d = {THR_W{1'b0}};
        end else if (evt_s) begin
            if ((thr_i != {THR_W{1'b0}}) && (thr_inc_s == thr_i)) begin
                irq_set_s = 1'b1;
                thr_cnt_d = {THR_W{1'b0}};
            end else begin
                thr_cnt_d = thr_inc_s;
            end
        end else begin
            thr_cnt_d = thr_cnt_q;
        end
        // A new event beats a software clear in the same cycle so it is never lost
        if (irq_set_s) begin
            irq_pend_d = 1'b1;
        end else if (irq_clr_i) begin
            irq_pend_d = 1'b0;
        end else begin
            irq_pend_d = irq_pend_q;
        end
    end

    // Edge-detect, threshold counter and pending flag registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pwm_d_q    <= 1'b0;
            thr_cnt_q  <= {THR_W{1'b0}};
            irq_pend_q <= 1'b0;
        end else begin
            pwm_d_q    <= pwm_d_d;
            thr_cnt_q  <= thr_cnt_d;
            irq_pend_q <= irq_pend_d;
        end
    end

`ifdef MODULATOR_REGS_PER_CNT_EN
    logic [31:0] per_cnt_q;
    logic [31:0] per_cnt_d;

    // Free-running period count, wraps naturally at 2^32
    always_comb begin
        if (evt_s) begin
            per_cnt_d = per_cnt_q + 32'd1;
        end else begin
            per_cnt_d = per_cnt_q;
        end
    end

    // Period counter register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            per_cnt_q <= 32'd0;
        end else begin
            per_cnt_q <= per_cnt_d;
        end
    end

    assign per_cnt_o = per_cnt_q;
`else
    assign per_cnt_o = 32'd0;
`endif

    assign irq_pend_o   = irq_pend_q;
    assign irq_pend_d_o = irq_pend_d;

endmodule

// File: rtl/modulator_bram_regs.sv
// PS-facing control/status register bank for the modulator on the soc BRAM
// port. Decodes word writes/reads into modulator enable, frequency select and
// duty, and raises a level interrupt after a programmable number of PWM periods.
// Optional feature: define MODULATOR_REGS_PER_CNT_EN to implement the PER_CNT
// register at 0x14; without it that offset reads 0.
module modulator_bram_regs
    import modulator_regs_pkg::*;
#(
    parameter int          DUTY_W   = 8,
    parameter int          THR_W    = 16,
    parameter logic [31:0] ID_VALUE = ID_VALUE_DEFAULT
) (
    input  logic                 pl_clk0_i,
    input  logic                 pl_reset_n_i,
    modulator_bram_regs_if.slave bram,
    input  logic                 pwm_i,
    output logic                 mod_en_o,
    output logic                 mod_sel_o,
    output logic [DUTY_W-1:0]    mod_duty_o,
    output logic                 irq_o
);

    logic              mod_en_q,  mod_en_d;
    logic              sel_q,     sel_d;
    logic              irq_en_q,  irq_en_d;
    logic [DUTY_W-1:0] duty_q,    duty_d;
    logic [THR_W-1:0]  thr_q,     thr_d;
    logic [31:0]       dout_q,    dout_d;
    logic              irq_q,     irq_d;

    logic              wr_s;
    logic              rd_s;
    reg_idx_e          idx_s;
    logic [31:0]       ctrl_img_s;
    logic [31:0]       ctrl_wr_s;
    logic [31:0]       duty_wr_s;
    logic [31:0]       thr_wr_s;
    logic              thr_wr_en_s;
    logic              thr_clr_s;
    logic              irq_clr_s;
    logic [31:0]       rdata_s;
    logic              irq_pend_s;
    logic              irq_pend_d_s;
    logic [31:0]       per_cnt_s;
    logic              unused_s;

    // Address bits outside [4:2] and bits above each field width are don't-care
    assign unused_s = ^{bram.addr[15:5], bram.addr[1:0], ctrl_wr_s[31:3],
                        duty_wr_s[31:DUTY_W], thr_wr_s[31:THR_W]};

    // Write decode and next state of the RW registers
    always_comb begin
        wr_s        = bram.en & (|bram.we);
        rd_s        = bram.en & ~(|bram.we);
        idx_s       = addr_to_idx(bram.addr[4:2]);

        ctrl_img_s                  = 32'd0;
        ctrl_img_s[CTRL_MOD_EN_BIT] = mod_en_q;
        ctrl_img_s[CTRL_SEL_BIT]    = sel_q;
        ctrl_img_s[CTRL_IRQ_EN_BIT] = irq_en_q;
        ctrl_wr_s   = merge_bytes(ctrl_img_s, bram.din, bram.we);
        duty_wr_s   = merge_bytes(32'(duty_q), bram.din, bram.we);
        thr_wr_s    = merge_bytes(32'(thr_q), bram.din, bram.we);

        mod_en_d    = mod_en_q;
        sel_d       = sel_q;
        irq_en_d    = irq_en_q;
        duty_d      = duty_q;
        thr_d       = thr_q;
        thr_wr_en_s = 1'b0;
        irq_clr_s   = 1'b0;

        if (wr_s) begin
            case (idx_s)
                REG_CTRL: begin
                    mod_en_d = ctrl_wr_s[CTRL_MOD_EN_BIT];
                    sel_d    = ctrl_wr_s[CTRL_SEL_BIT];
                    irq_en_d = ctrl_wr_s[CTRL_IRQ_EN_BIT];
                end
                REG_DUTY: begin
                    duty_d = duty_wr_s[DUTY_W-1:0];
                end
                REG_IRQ_THR: begin
                    thr_d       = thr_wr_s[THR_W-1:0];
                    thr_wr_en_s = 1'b1;
                end
                REG_IRQ_CLR: begin
                    irq_clr_s = bram.we[0] & bram.din[0];
                end
                default: begin
                    thr_wr_en_s = 1'b0;
                end
            endcase
        end else begin
            thr_wr_en_s = 1'b0;
        end

        // Any threshold write, or turning the modulator off, restarts the count
        thr_clr_s = thr_wr_en_s | (mod_en_q & ~mod_en_d);
        irq_d     = irq_pend_d_s & irq_en_d;
    end

    // Read data mux and read-port output register next state
    always_comb begin
        case (idx_s)
            REG_CTRL:    rdata_s = ctrl_img_s;
            REG_DUTY:    rdata_s = 32'(duty_q);
            REG_IRQ_THR: rdata_s = 32'(thr_q);
            REG_STATUS: begin
                rdata_s                    = 32'd0;
                rdata_s[STAT_IRQ_PEND_BIT] = irq_pend_s;
                rdata_s[STAT_PWM_BIT]      = pwm_i;
            end
            REG_IRQ_CLR: rdata_s = 32'd0;
            REG_PER_CNT: rdata_s = per_cnt_s;
            REG_ID:      rdata_s = ID_VALUE;
            default:     rdata_s = 32'd0;
        endcase

        // Port clear wins over a read; writes leave the last read data in place
        if (bram.rst) begin
            dout_d = 32'd0;
        end else if (rd_s) begin
            dout_d = rdata_s;
        end else begin
            dout_d = dout_q;
        end
    end

    // Register storage and registered outputs
    always_ff @(posedge pl_clk0_i or negedge pl_reset_n_i) begin
        if (!pl_reset_n_i) begin
            mod_en_q <= 1'b0;
            sel_q    <= 1'b0;
            irq_en_q <= 1'b0;
            duty_q   <= {DUTY_W{1'b0}};
            thr_q    <= {THR_W{1'b0}};
            dout_q   <= 32'd0;
            irq_q    <= 1'b0;
        end else begin
            mod_en_q <= mod_en_d;
            sel_q    <= sel_d;
            irq_en_q <= irq_en_d;
            duty_q   <= duty_d;
            thr_q    <= thr_d;
            dout_q   <= dout_d;
            irq_q    <= irq_d;
        end
    end

    modulator_period_irq #(
        .THR_W (THR_W)
    ) u_period_irq (
        .clk_i        (pl_clk0_i),
        .rst_ni       (pl_reset_n_i),
        .pwm_i        (pwm_i),
        .mod_en_i     (mod_en_q),
        .thr_i        (thr_q),
        .thr_clr_i    (thr_clr_s),
        .irq_clr_i    (irq_clr_s),
        .irq_pend_o   (irq_pend_s),
        .irq_pend_d_o (irq_pend_d_s),
        .per_cnt_o    (per_cnt_s)
    );

    assign bram.dout  = dout_q;
    assign mod_en_o   = mod_en_q;
    assign mod_sel_o  = sel_q;
    assign mod_duty_o = duty_q;
    assign irq_o      = irq_q;

endmodule

// File: tb/tb_modulator_bram_regs.sv
// Self-checking bench for modulator_bram_regs. Read data is checked through a
// scoreboard queue filled when a read is issued and drained one cycle later;
// control outputs and the interrupt are checked inline in each scenario task.
module tb_modulator_bram_regs;

    localparam logic [31:0] ID_EXP = 32'h4D4F_4401;
`ifdef MODULATOR_REGS_PER_CNT_EN
    localparam bit PER_EN = 1'b1;
`else
    localparam bit PER_EN = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic       pwm;
    logic       mod_en;
    logic       mod_sel;
    logic [7:0] duty;
    logic       irq;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] exp_q[$];
    string       tag_q[$];
    logic        rd_seen = 1'b0;

    modulator_bram_regs_if bif ();

    modulator_bram_regs #(
        .DUTY_W   (8),
        .THR_W    (16),
        .ID_VALUE (32'h4D4F_4401)
    ) dut (
        .pl_clk0_i    (clk),
        .pl_reset_n_i (rst_n),
        .bram         (bif.slave),
        .pwm_i        (pwm),
        .mod_en_o     (mod_en),
        .mod_sel_o    (mod_sel),
        .mod_duty_o   (duty),
        .irq_o        (irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Remember whether a read was presented at this edge
    always @(posedge clk) rd_seen <= (bif.en === 1'b1) && (bif.we === 4'h0);

    // Scoreboard: compare the read data one cycle after the read strobe
    always @(negedge clk) begin
        if (rd_seen) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL sb_underflow: read data %h with no expectation", bif.dout);
            end else begin
                logic [31:0] e;
                string t;
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                if (bif.dout !== e) begin
                    n_err++;
                    $display("FAIL %s: got %h want %h", t, bif.dout, e);
                end
            end
        end
    end

    task automatic bus_write(input logic [15:0] a, input logic [31:0] d, input logic [3:0] be);
        @(negedge clk);
        bif.addr = a;
        bif.din  = d;
        bif.we   = be;
        bif.en   = 1'b1;
        @(negedge clk);
        bif.en   = 1'b0;
        bif.we   = 4'h0;
    endtask

    task automatic bus_read(input logic [15:0] a, input logic [31:0] e, input string t);
        @(negedge clk);
        exp_q.push_back(e);
        tag_q.push_back(t);
        bif.addr = a;
        bif.we   = 4'h0;
        bif.en   = 1'b1;
        @(negedge clk);
        bif.en   = 1'b0;
    endtask

    task automatic pwm_period();
        @(negedge clk);
        pwm = 1'b1;
        @(negedge clk);
        @(negedge clk);
        pwm = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({mod_en, mod_sel, duty, irq} !== 11'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got %b want 0", {mod_en, mod_sel, duty, irq});
        end
        n_cmp++;
        if (bif.dout !== 32'd0) begin
            n_err++;
            $display("FAIL reset_dout: got %h want 0", bif.dout);
        end
        rst_n = 1'b1;
        bus_read(16'h0018, ID_EXP, "read_id");
        bus_read(16'h0000, 32'd0, "read_ctrl_reset");
        bus_read(16'h0008, 32'd0, "read_thr_reset");
        bus_read(16'h000C, 32'd0, "read_status_reset");
        bus_read(16'h0014, 32'd0, "read_percnt_reset");
    endtask

    task automatic test_write();
        bus_write(16'h0000, 32'h0000_0003, 4'hF);
        n_cmp++;
        if ({mod_en, mod_sel} !== 2'b11) begin
            n_err++;
            $display("FAIL ctrl_write: got %b want 11", {mod_en, mod_sel});
        end
        bus_write(16'h0004, 32'h0000_0080, 4'hF);
        n_cmp++;
        if (duty !== 8'h80) begin
            n_err++;
            $display("FAIL duty_write: got %h want 80", duty);
        end
        bus_write(16'h0004, 32'h0000_5500, 4'h2);
        n_cmp++;
        if (duty !== 8'h80) begin
            n_err++;
            $display("FAIL duty_lane1_ignored: got %h want 80", duty);
        end
        bus_write(16'h0000, 32'h0000_0000, 4'h2);
        n_cmp++;
        if ({mod_en, mod_sel} !== 2'b11) begin
            n_err++;
            $display("FAIL ctrl_lane1_ignored: got %b want 11", {mod_en, mod_sel});
        end
        bus_write(16'h001C, 32'hFFFF_FFFF, 4'hF);
        bus_write(16'h000C, 32'hFFFF_FFFF, 4'hF);
        bus_read(16'h0004, 32'h0000_0080, "read_duty");
        bus_read(16'h0000, 32'h0000_0003, "read_ctrl");
        bus_read(16'h001C, 32'd0, "read_rsvd");
        bus_read(16'h000C, 32'd0, "read_status_ro");
        bus_read(16'h001A, ID_EXP, "read_id_alias");
    endtask

    task automatic test_irq();
        bus_write(16'h0008, 32'd4, 4'hF);
        bus_write(16'h0000, 32'h0000_0007, 4'hF);
        repeat (3) pwm_period();
        n_cmp++;
        if (irq !== 1'b0) begin
            n_err++;
            $display("FAIL irq_early: got %b want 0", irq);
        end
        @(negedge clk);
        pwm = 1'b1;
        n_cmp++;
        if (irq !== 1'b0) begin
            n_err++;
            $display("FAIL irq_before_4th_edge: got %b want 0", irq);
        end
        @(negedge clk);
        n_cmp++;
        if (irq !== 1'b1) begin
            n_err++;
            $display("FAIL irq_after_4th_edge: got %b want 1", irq);
        end
        @(negedge clk);
        pwm = 1'b0;
        @(negedge clk);
        bus_read(16'h000C, 32'h0000_0001, "status_pend");
        bus_write(16'h0010, 32'h0000_0001, 4'h1);
        n_cmp++;
        if (irq !== 1'b0) begin
            n_err++;
            $display("FAIL irq_clear: got %b want 0", irq);
        end
        bus_read(16'h000C, 32'd0, "status_cleared");
        bus_read(16'h0010, 32'd0, "read_irq_clr");
    endtask

    task automatic test_clear_collision();
        repeat (3) pwm_period();
        @(negedge clk);
        pwm      = 1'b1;
        bif.addr = 16'h0010;
        bif.din  = 32'h0000_0001;
        bif.we   = 4'h1;
        bif.en   = 1'b1;
        @(negedge clk);
        bif.en   = 1'b0;
        bif.we   = 4'h0;
        n_cmp++;
        if (irq !== 1'b1) begin
            n_err++;
            $display("FAIL collision_set_wins: got %b want 1", irq);
        end
        bus_read(16'h000C, 32'h0000_0003, "status_pend_pwm_high");
        pwm = 1'b0;
        bus_write(16'h0000, 32'h0000_0001, 4'hF);
        n_cmp++;
        if (irq !== 1'b0) begin
            n_err++;
            $display("FAIL irq_en_gate: got %b want 0", irq);
        end
        bus_read(16'h000C, 32'h0000_0001, "status_pend_masked");
        bus_write(16'h0000, 32'h0000_0007, 4'hF);
        n_cmp++;
        if (irq !== 1'b1) begin
            n_err++;
            $display("FAIL irq_en_reenable: got %b want 1", irq);
        end
        bus_write(16'h0010, 32'h0000_0001, 4'hF);
    endtask

    task automatic test_thr_reset();
        repeat (3) pwm_period();
        bus_write(16'h0000, 32'h0000_0006, 4'hF);
        bus_write(16'h0000, 32'h0000_0007, 4'hF);
        repeat (3) pwm_period();
        n_cmp++;
        if (irq !== 1'b0) begin
            n_err++;
            $display("FAIL modoff_resets_cnt: got %b want 0", irq);
        end
        pwm_period();
        n_cmp++;
        if (irq !== 1'b1) begin
            n_err++;
            $display("FAIL modoff_then_4: got %b want 1", irq);
        end
        bus_write(16'h0010, 32'h0000_0001, 4'hF);
        repeat (3) pwm_period();
        bus_write(16'h0008, 32'd4, 4'hF);
        repeat (3) pwm_period();
        n_cmp++;
        if (irq !== 1'b0) begin
            n_err++;
            $display("FAIL thrwr_resets_cnt: got %b want 0", irq);
        end
        pwm_period();
        n_cmp++;
        if (irq !== 1'b1) begin
            n_err++;
            $display("FAIL thrwr_then_4: got %b want 1", irq);
        end
        bus_write(16'h0010, 32'h0000_0001, 4'hF);
    endtask

    task automatic test_per_cnt();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        bus_write(16'h0000, 32'h0000_0001, 4'hF);
        repeat (10) pwm_period();
        bus_read(16'h0014, PER_EN ? 32'd10 : 32'd0, "percnt_10");
        bus_write(16'h0000, 32'h0000_0000, 4'hF);
        repeat (5) pwm_period();
        bus_read(16'h0014, PER_EN ? 32'd10 : 32'd0, "percnt_disabled");
    endtask

    task automatic test_bram_rst();
        bus_write(16'h0004, 32'h0000_005A, 4'hF);
        bus_read(16'h0018, ID_EXP, "id_before_rst");
        @(negedge clk);
        exp_q.push_back(32'd0);
        tag_q.push_back("rst_over_read");
        bif.addr = 16'h0018;
        bif.we   = 4'h0;
        bif.en   = 1'b1;
        bif.rst  = 1'b1;
        @(negedge clk);
        bif.en   = 1'b0;
        bif.rst  = 1'b0;
        bus_read(16'h0018, ID_EXP, "id_after_rst");
        bus_write(16'h0000, 32'h0000_0002, 4'hF);
        n_cmp++;
        if (bif.dout !== ID_EXP) begin
            n_err++;
            $display("FAIL write_keeps_dout: got %h want %h", bif.dout, ID_EXP);
        end
        @(negedge clk);
        bif.rst = 1'b1;
        @(negedge clk);
        bif.rst = 1'b0;
        n_cmp++;
        if (bif.dout !== 32'd0) begin
            n_err++;
            $display("FAIL rst_alone: got %h want 0", bif.dout);
        end
        bus_read(16'h0004, 32'h0000_005A, "duty_survives_rst");
    endtask

    task automatic test_async_reset();
        bus_write(16'h0008, 32'd1, 4'hF);
        bus_write(16'h0000, 32'h0000_0007, 4'hF);
        pwm_period();
        n_cmp++;
        if (irq !== 1'b1) begin
            n_err++;
            $display("FAIL thr1_irq: got %b want 1", irq);
        end
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({irq, mod_en, mod_sel} !== 3'b000) begin
            n_err++;
            $display("FAIL async_reset: got %b want 000", {irq, mod_en, mod_sel});
        end
        @(negedge clk);
        rst_n = 1'b1;
        bus_read(16'h0008, 32'd0, "thr_after_reset");
        bus_read(16'h000C, 32'd0, "status_after_reset");
    endtask

    initial begin
        rst_n    = 1'b0;
        pwm      = 1'b0;
        bif.addr = 16'h0000;
        bif.din  = 32'd0;
        bif.we   = 4'h0;
        bif.en   = 1'b0;
        bif.rst  = 1'b0;
        test_reset();
        test_write();
        test_irq();
        test_clear_collision();
        test_thr_reset();
        test_per_cnt();
        test_bram_rst();
        test_async_reset();
        repeat (3) @(negedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL sb_leftover: got %0d pending want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
